psum_accum_layer3: RTL
======================

PSUM_ACCUM_LAYER3 -- requirements
Module: psum_accum_layer3

Interface
REQ-001 Parameter MACRO_NUM, default 4, number of CIM macros whose outputs are summed.
REQ-002 Parameter ADC_CYC, default 2, cycles adc is held high per phase; legal range 1..15.
REQ-003 Parameter ACC_W, default 8, per-channel accumulator width; legal range 4..16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request one 4-phase accumulation; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 enable  output  1  macro enable, to macro array.
REQ-009 adc  output  1  macro ADC conversion strobe.
REQ-010 chs_ps  output  2  macro partial-sum phase select.
REQ-011 macro_dout  input  64*MACRO_NUM*4  macro results; channel l of macro k at bits (k*64+l)*4+3 : (k*64+l)*4, unsigned.
REQ-012 out_valid  output  1  psum_out holds a completed result.
REQ-013 out_ready  input  1  downstream accepts psum_out.
REQ-014 psum_out  output  64*ACC_W  channel l sum at bits l*ACC_W+ACC_W-1 : l*ACC_W, unsigned.

Function
REQ-015 FSM states SHALL be IDLE, PRE, CONV, SAMP, DONE; every output SHALL be driven from registers.
REQ-016 IDLE with start=1 SHALL go to PRE, clear all 64 accumulators and the phase counter to 0.
REQ-017 PRE SHALL last 1 cycle with enable=1, adc=0, chs_ps=phase, then go to CONV.
REQ-018 CONV SHALL last exactly ADC_CYC cycles with enable=1, adc=1, then go to SAMP.
REQ-019 SAMP SHALL last 1 cycle with enable=1, adc=0, and add, per channel l, the sum over all k of macro_dout channel l of macro k into accumulator l.
REQ-020 Leaving SAMP: phase<3 SHALL increment phase and go to PRE; phase=3 SHALL go to DONE.
REQ-021 DONE SHALL hold enable=0, adc=0, out_valid=1, psum_out stable until out_valid&&out_ready, then go to IDLE with out_valid=0 next cycle.
REQ-022 With start sampled at edge T, enable SHALL rise at T+1 and out_valid at T+1+4*(ADC_CYC+2) (cycle 17 for default).
REQ-023 start while busy SHALL be ignored, including the DONE handshake cycle; no request SHALL be queued.
REQ-024 chs_ps SHALL change only on PRE entry and SHALL hold its value through CONV and SAMP.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 Intermediate accumulator arithmetic SHALL be ACC_W+2 bits wide before the width rule of REQ-031/032 is applied.

Reset
REQ-027 rst_n low SHALL, asynchronously, force state IDLE, phase 0, all accumulators 0.
REQ-028 Reset values: busy=0, enable=0, adc=0, chs_ps=0, out_valid=0, psum_out=0.
REQ-029 rst_n assertion mid-sequence SHALL abandon the sequence with no result delivered; release SHALL require a new start.
REQ-030 After rst_n deasserts, the first edge SHALL already honour start.

Configuration
REQ-031 With PSUM_SAT_EN defined, each accumulator SHALL saturate at 2^ACC_W-1 and stay there for the rest of the sequence.
REQ-032 Without PSUM_SAT_EN, each accumulator SHALL wrap modulo 2^ACC_W; all other behaviour SHALL be identical.

Verification
REQ-033 Defaults, macro_dout all 4'h1, start pulse -> chs_ps 0,1,2,3 each 4 cycles, out_valid at cycle 17, every channel = 16.
REQ-034 Defaults, all 4'hF, out_ready=1 -> every channel = 240, out_valid high exactly 1 cycle, busy low the next cycle.
REQ-035 ACC_W=6, all 4'hF -> with PSUM_SAT_EN every channel = 63; without it every channel = 240 mod 64 = 48.
REQ-036 Defaults, out_ready=0 for 5 cycles in DONE, start pulsed in DONE -> psum_out stable, start ignored, IDLE after handshake.
REQ-037 rst_n low during CONV of phase 2 -> all outputs 0 immediately; new start -> fresh result with no carry-over from the aborted run.
REQ-038 Channel 5 of macro 2 = 4'h7, all others 0, ADC_CYC=3 -> adc high 3 cycles per phase, channel 5 = 28, all others 0, out_valid at cycle 21.

Source files
------------

// File: rtl/psum_accum_layer3.sv
// Four-phase partial-sum accumulator sequencing a CIM macro array and summing 64 channels across macros.
// Optional build macro PSUM_SAT_EN: accumulators saturate instead of wrapping.
module psum_accum_layer3 #(
   parameter int unsigned MACRO_NUM = 4,
   parameter int unsigned ADC_CYC   = 2,
   parameter int unsigned ACC_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         enable,
   output logic                         adc,
   output logic [1:0]                   chs_ps,
   input  logic [64*MACRO_NUM*4-1:0]    macro_dout,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [64*ACC_W-1:0]          psum_out
);

   localparam int unsigned CH    = 64;
   localparam int unsigned DW    = 4;
   localparam int unsigned EXT_W = ACC_W + 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {IDLE, PRE, CONV, SAMP, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         phase_q, phase_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         chs_ps_q, chs_ps_d;
   logic               busy_q, busy_d;
   logic               enable_q, enable_d;
   logic               adc_q, adc_d;
   logic               out_valid_q, out_valid_d;
   logic               acc_clr, acc_add;

   logic [ACC_W-1:0]   acc_q [CH];
   logic [ACC_W-1:0]   acc_d [CH];
   logic [EXT_W-1:0]   chan_sum [CH];

   // Per-channel sum of all macro outputs for the current phase
   always_comb begin
      for (int l = 0; l < int'(CH); l++) begin
         chan_sum[l] = '0;
         for (int k = 0; k < int'(MACRO_NUM); k++) begin
            chan_sum[l] = chan_sum[l] + EXT_W'(macro_dout[(k*int'(CH)+l)*int'(DW) +: DW]);
         end
      end
   end

`ifdef PSUM_SAT_EN
   localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_W{1'b1}});
   logic [EXT_W-1:0]   acc_ext [CH];

   // Accumulator update, clamped at full scale
   always_comb begin
      for (int l = 0; l < int'(CH); l++) begin
         acc_ext[l] = EXT_W'(acc_q[l]) + chan_sum[l];
         acc_d[l]   = acc_q[l];
         if (acc_clr) begin
            acc_d[l] = '0;
         end else if (acc_add) begin
            acc_d[l] = (acc_ext[l] > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(acc_ext[l]);
         end
      end
   end
`else
   // Accumulator update, wrapping modulo 2^ACC_W
   always_comb begin
      for (int l = 0; l < int'(CH); l++) begin
         acc_d[l] = acc_q[l];
         if (acc_clr) begin
            acc_d[l] = '0;
         end else if (acc_add) begin
            acc_d[l] = ACC_W'(EXT_W'(acc_q[l]) + chan_sum[l]);
         end
      end
   end
`endif

   // Next-state logic; outputs are registered from the next state so they align with it
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      chs_ps_d = chs_ps_q;
      acc_clr  = 1'b0;
      acc_add  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = PRE;
               phase_d  = 2'd0;
               chs_ps_d = 2'd0;
               acc_clr  = 1'b1;
            end
         end
         PRE: begin
            state_d = CONV;
            cnt_d   = '0;
         end
         CONV: begin
            if (cnt_q == CNT_W'(ADC_CYC - 1)) begin
               state_d = SAMP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SAMP: begin
            acc_add = 1'b1;
            if (phase_q == 2'd3) begin
               state_d = DONE;
            end else begin
               state_d  = PRE;
               phase_d  = phase_q + 2'd1;
               chs_ps_d = phase_q + 2'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d      = (state_d != IDLE);
      enable_d    = (state_d == PRE) || (state_d == CONV) || (state_d == SAMP);
      adc_d       = (state_d == CONV);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= 2'd0;
         cnt_q       <= '0;
         chs_ps_q    <= 2'd0;
         busy_q      <= 1'b0;
         enable_q    <= 1'b0;
         adc_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         chs_ps_q    <= chs_ps_d;
         busy_q      <= busy_d;
         enable_q    <= enable_d;
         adc_q       <= adc_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < int'(CH); l++) acc_q[l] <= '0;
      end else begin
         for (int l = 0; l < int'(CH); l++) acc_q[l] <= acc_d[l];
      end
   end

   assign busy      = busy_q;
   assign enable    = enable_q;
   assign adc       = adc_q;
   assign chs_ps    = chs_ps_q;
   assign out_valid = out_valid_q;

   for (genvar g = 0; g < int'(CH); g++) begin : g_out
      assign psum_out[g*ACC_W +: ACC_W] = acc_q[g];
   end

endmodule
